// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V core pipeline.
// Fetch FSM states, XLEN and the canonical NOP encoding.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        F_INIT,
        F_FETCH,
        F_DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction and its PC
// while IF/ID is stalled.
module fetch_skid_buf
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic            pop,
    input  logic            clear,
    input  logic [XLEN-1:0] push_instr,
    input  logic [XLEN-1:0] push_pc,
    output logic            full,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            full  <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (push) begin
            full  <= 1'b1;
            instr <= push_instr;
            pc    <= push_pc;
        end else if (pop) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC sequencing, redirects, imem handshake,
// IF/ID pipeline register and interrupt return PC.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_IF,
    input  logic        stall_IF_ID,
    input  logic        flush_IF_ID,
    input  logic        pc_next_sel,
    input  logic [31:0] pc_target,
    input  logic        interrupt_en,
    input  logic        mret_ID,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_ID,
    output logic [31:0] pc_ID,
    output logic [31:0] pc_plus4_ID,
    output logic        valid_ID,
    output logic [31:0] epc
);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] drop_addr;
    logic [XLEN-1:0] redir_pc;
    logic            redirect;
    logic            accept;
    logic            keep;
    logic            skid_full;
    logic            skid_push;
    logic            skid_pop;
    logic [XLEN-1:0] skid_instr;
    logic [XLEN-1:0] skid_pc;

    always_comb begin
        redirect = interrupt_en | pc_next_sel | mret_ID;
        redir_pc = pc + 32'd4;
        priority case (1'b1)
            interrupt_en: redir_pc = TRAP_VEC;
            pc_next_sel:  redir_pc = pc_target;
            mret_ID:      redir_pc = epc;
            default:      redir_pc = pc + 32'd4;
        endcase
    end

    // In F_DROP the abandoned request stays on the bus until it completes.
    assign imem_req  = (state != F_INIT) && !skid_full;
    assign imem_addr = (state == F_DROP) ? drop_addr : pc;
    assign accept    = (state == F_FETCH) && imem_req && imem_ready;
    assign keep      = accept && !redirect && !stall_IF;

    assign skid_push = keep && stall_IF_ID && !flush_IF_ID;
    assign skid_pop  = skid_full && !stall_IF_ID && !flush_IF_ID;

    always_comb begin
        state_nxt = state;
        unique case (state)
            F_INIT:  state_nxt = F_FETCH;
            F_FETCH: if (redirect && imem_req && !imem_ready)
                         state_nxt = F_DROP;
            F_DROP:  if (imem_ready)
                         state_nxt = F_FETCH;
            default: state_nxt = F_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= F_INIT;
            pc        <= RESET_PC;
            drop_addr <= '0;
        end else begin
            state <= state_nxt;
            if (redirect)
                pc <= redir_pc;
            else if (keep)
                pc <= pc + 32'd4;
            if (state == F_FETCH && state_nxt == F_DROP)
                drop_addr <= pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            epc <= '0;
        end else if (interrupt_en) begin
            epc <= valid_ID ? pc_ID : pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush_IF_ID) begin
            valid_ID <= 1'b0;
            instr_ID <= NOP_INSTR;
            if (!rst_n) begin
                pc_ID       <= '0;
                pc_plus4_ID <= '0;
            end
        end else if (!stall_IF_ID) begin
            if (skid_full) begin
                valid_ID    <= 1'b1;
                instr_ID    <= skid_instr;
                pc_ID       <= skid_pc;
                pc_plus4_ID <= skid_pc + 32'd4;
            end else if (keep) begin
                valid_ID    <= 1'b1;
                instr_ID    <= imem_rdata;
                pc_ID       <= pc;
                pc_plus4_ID <= pc + 32'd4;
            end else begin
                valid_ID <= 1'b0;
                instr_ID <= NOP_INSTR;
            end
        end
    end

    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (skid_push),
        .pop        (skid_pop),
        .clear      (flush_IF_ID),
        .push_instr (imem_rdata),
        .push_pc    (pc),
        .full       (skid_full),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an expected-instruction queue
// checked whenever IF/ID takes a new valid instruction.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_IF, stall_IF_ID, flush_IF_ID;
    logic        pc_next_sel, interrupt_en, mret_ID;
    logic [31:0] pc_target;
    logic        imem_req, imem_ready;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] instr_ID, pc_ID, pc_plus4_ID, epc;
    logic        valid_ID;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic        upd_q = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(logic [31:0] a);
        return {a[19:0], 12'h093};
    endfunction

    assign imem_rdata = imem_ready ? instr_of(imem_addr) : 32'hDEAD_BEEF;

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_IF     (stall_IF),
        .stall_IF_ID  (stall_IF_ID),
        .flush_IF_ID  (flush_IF_ID),
        .pc_next_sel  (pc_next_sel),
        .pc_target    (pc_target),
        .interrupt_en (interrupt_en),
        .mret_ID      (mret_ID),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .instr_ID     (instr_ID),
        .pc_ID        (pc_ID),
        .pc_plus4_ID  (pc_plus4_ID),
        .valid_ID     (valid_ID),
        .epc          (epc)
    );

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // IF/ID took new contents at the last edge unless it was held.
    always @(posedge clk) upd_q <= !stall_IF_ID || flush_IF_ID;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && valid_ID === 1'b1 && upd_q) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid_pc", pc_ID, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("pc_ID", pc_ID, e);
                check("instr_ID", instr_ID, instr_of(e));
                check("pc_plus4_ID", pc_plus4_ID, e + 32'd4);
            end
        end
    end

    initial begin
        rst_n = 0; stall_IF = 0; stall_IF_ID = 0; flush_IF_ID = 0;
        pc_next_sel = 0; interrupt_en = 0; mret_ID = 0;
        pc_target = '0; imem_ready = 0;
        tick(); tick();
        check("rst_req", imem_req, 0);
        check("rst_valid", valid_ID, 0);
        check("rst_instr", instr_ID, 32'h13);
        check("rst_pc_ID", pc_ID, 0);
        check("rst_plus4", pc_plus4_ID, 0);
        check("rst_epc", epc, 0);
        rst_n = 1;
        check("init_req", imem_req, 0);
        tick();
        check("first_addr", imem_addr, 32'h0);
        check("first_req", imem_req, 1);
        check("first_valid", valid_ID, 0);

        imem_ready = 1;
        exp_q.push_back(32'h0); tick();
        check("seq_addr4", imem_addr, 32'h4);
        exp_q.push_back(32'h4); tick();
        check("seq_addr8", imem_addr, 32'h8);

        imem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("wait_addr8", imem_addr, 32'h8);
            check("wait_req", imem_req, 1);
            check("wait_bubble", valid_ID, 0);
        end
        imem_ready = 1;
        exp_q.push_back(32'h8); tick();
        check("addr_c", imem_addr, 32'hC);

        imem_ready = 0; pc_next_sel = 1; pc_target = 32'h40;
        tick();
        pc_next_sel = 0;
        check("drop_hold_addr", imem_addr, 32'hC);
        check("drop_hold_req", imem_req, 1);
        tick();
        check("drop_hold_addr2", imem_addr, 32'hC);
        imem_ready = 1;
        tick();
        check("drop_new_addr", imem_addr, 32'h40);
        check("drop_discard", valid_ID, 0);

        pc_next_sel = 1; pc_target = 32'h10;
        tick();
        pc_next_sel = 0;
        check("redir_ready_addr", imem_addr, 32'h10);
        check("redir_ready_discard", valid_ID, 0);

        stall_IF_ID = 1;
        exp_q.push_back(32'h10); tick();
        check("skid_full_req", imem_req, 0);
        check("skid_hold_valid", valid_ID, 0);
        tick();
        check("skid_full_req2", imem_req, 0);
        stall_IF_ID = 0;
        tick();
        check("skid_drain_addr", imem_addr, 32'h14);
        check("skid_drain_req", imem_req, 1);
        exp_q.push_back(32'h14); tick();
        exp_q.push_back(32'h18); tick();
        exp_q.push_back(32'h1C); tick();
        exp_q.push_back(32'h20); tick();
        check("pre_irq_pc", imem_addr, 32'h24);

        interrupt_en = 1;
        tick();
        interrupt_en = 0;
        check("irq_epc", epc, 32'h20);
        check("irq_addr", imem_addr, 32'h100);
        check("irq_bubble", valid_ID, 0);
        exp_q.push_back(32'h100); tick();
        mret_ID = 1;
        tick();
        mret_ID = 0;
        check("mret_addr", imem_addr, 32'h20);
        check("mret_bubble", valid_ID, 0);
        exp_q.push_back(32'h20); tick();
        exp_q.push_back(32'h24); tick();

        interrupt_en = 1; pc_next_sel = 1; pc_target = 32'h80;
        flush_IF_ID = 1; stall_IF_ID = 1;
        tick();
        interrupt_en = 0; pc_next_sel = 0; flush_IF_ID = 0;
        check("prio_addr", imem_addr, 32'h100);
        check("prio_epc", epc, 32'h24);
        check("flush_valid", valid_ID, 0);
        check("flush_instr", instr_ID, 32'h13);

        tick();
        check("skid_fill_req", imem_req, 0);
        flush_IF_ID = 1;
        tick();
        check("flush_clr_req", imem_req, 1);
        check("flush_clr_addr", imem_addr, 32'h104);
        flush_IF_ID = 0; stall_IF_ID = 0; imem_ready = 0;
        tick();
        check("flush_clr_valid", valid_ID, 0);

        imem_ready = 1; pc_next_sel = 1; pc_target = 32'hFFFF_FFFC;
        tick();
        pc_next_sel = 0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        exp_q.push_back(32'hFFFF_FFFC); tick();
        check("wrap_next", imem_addr, 32'h0);
        imem_ready = 0;
        tick();
        check("queue_empty", exp_q.size(), 0);

        rst_n = 0;
        tick();
        check("midrst_req", imem_req, 0);
        check("midrst_valid", valid_ID, 0);
        check("midrst_epc", epc, 0);
        check("midrst_pc_ID", pc_ID, 0);
        rst_n = 1;
        tick();
        check("midrst_addr", imem_addr, 32'h0);
        check("midrst_req2", imem_req, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0000_0000, first fetch address; TRAP_VEC, 32'h0000_0100, interrupt handler address.
REQ-002 Ports SHALL be (name  direction  width  meaning):
  clk  in  1  single clock; all state changes on rising edge
  rst_n  in  1  synchronous, active-low reset
  stall_IF  in  1  hold PC, from hazard unit
  stall_IF_ID  in  1  hold IF/ID register, from hazard unit
  flush_IF_ID  in  1  squash IF/ID contents, from hazard unit
  pc_next_sel  in  1  taken branch/jump redirect
  pc_target  in  32  branch/jump target
  interrupt_en  in  1  take interrupt, from hazard unit
  mret_ID  in  1  return from interrupt, resolved in ID
  imem_req  out  1  fetch request valid
  imem_addr  out  32  fetch address, word aligned
  imem_ready  in  1  response valid this cycle
  imem_rdata  in  32  fetched instruction
  instr_ID  out  32  IF/ID instruction
  pc_ID  out  32  IF/ID PC
  pc_plus4_ID  out  32  pc_ID + 4
  valid_ID  out  1  IF/ID holds a real instruction
  epc  out  32  saved interrupt return PC

Function
REQ-003 The FSM SHALL have states F_INIT, F_FETCH and F_DROP; F_INIT lasts exactly one cycle after reset release, then goes to F_FETCH.
REQ-004 imem_req SHALL be 0 in F_INIT, and 1 in F_FETCH/F_DROP unless the skid buffer is full.
REQ-005 imem_addr and imem_req SHALL stay stable while imem_req=1 and imem_ready=0 (valid/ready hold).
REQ-006 Redirect priority SHALL be interrupt_en (TRAP_VEC) > pc_next_sel (pc_target) > mret_ID (epc) > sequential (pc+4).
REQ-007 The PC SHALL advance by 4 only on an accepted response (imem_ready=1 in F_FETCH) with stall_IF=0 and no redirect.
REQ-008 A redirect SHALL load the PC in the same cycle regardless of stall_IF.
REQ-009 A redirect with a request outstanding and imem_ready=0 SHALL enter F_DROP; the old request is held until imem_ready, its data is discarded, and the FSM then returns to F_FETCH at the new PC.
REQ-010 A redirect coinciding with imem_ready=1 SHALL discard that data and stay in F_FETCH.
REQ-011 An accepted response SHALL load IF/ID (instr, pc, valid=1) when stall_IF_ID=0.
REQ-012 An accepted response arriving while stall_IF_ID=1 SHALL go into a one-entry skid buffer, delivered to IF/ID on the first unstalled cycle, with a new response then accepted directly only after the buffer drains.
REQ-013 With stall_IF_ID=0 and no response or buffered data, IF/ID SHALL load a bubble: valid_ID=0, instr_ID=NOP (32'h0000_0013).
REQ-014 flush_IF_ID SHALL load a bubble into IF/ID and clear the skid buffer, overriding stall_IF_ID.
REQ-015 On interrupt_en, epc SHALL load pc_ID if valid_ID=1, else the current fetch PC; epc SHALL be otherwise unchanged.
REQ-016 pc_plus4_ID SHALL be registered together with pc_ID, using 32-bit modular addition (wraps at 2^32).

Reset
REQ-017 While rst_n=0 at a clock edge: PC=RESET_PC, state=F_INIT, skid buffer empty, valid_ID=0, instr_ID=NOP, pc_ID=0, pc_plus4_ID=0, epc=0, imem_req=0.
REQ-018 Reset mid-request SHALL abandon the outstanding fetch; imem shall tolerate request withdrawal under reset.

Structure
REQ-019 XLEN, NOP_INSTR and the enum fetch_state_t SHALL live in shared package riscv_pkg.
REQ-020 The skid buffer SHALL be sub-module fetch_skid_buf (32-bit data + 32-bit PC, one entry, valid flag).

Verification
REQ-021 Reset, imem_ready always 1 -> first imem_addr 0x0 in cycle 2, then 0x4, 0x8; valid_ID rises one cycle after each response.
REQ-022 imem_ready delayed 3 cycles at 0x8 -> imem_addr holds 0x8 for 4 cycles; no bubble is marked valid.
REQ-023 pc_next_sel=1, pc_target=0x40 while fetch of 0xC is pending -> F_DROP, 0xC data discarded, next valid instruction has pc_ID=0x40.
REQ-024 stall_IF_ID=1 for 2 cycles while response at 0x10 arrives -> skid holds it; pc_ID=0x10 appears after stall release; no instruction lost or duplicated.
REQ-025 interrupt_en=1 with valid_ID=1, pc_ID=0x20 -> epc=0x20, next fetch 0x100, IF/ID bubble; later mret_ID=1 -> fetch resumes at 0x20.
REQ-026 interrupt_en and pc_next_sel together, plus flush_IF_ID with stall_IF_ID -> trap vector wins; IF/ID is flushed.
